// File: rtl/matmul_tile_sched_pkg.sv
// Shared types and constants for the matmul tile scheduler: array edge, FSM state
// encoding and the tile-counter width helper.
package matmul_tile_sched_pkg;

    localparam int TILE = 4;
    localparam int DRW  = 2;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_CLEAR     = 4'd1,
        S_ISSUE     = 4'd2,
        S_WAIT_DONE = 4'd3,
        S_NEXT_K    = 4'd4,
        S_DRAIN     = 4'd5,
        S_NEXT_TILE = 4'd6,
        S_DONE      = 4'd7,
        S_ERR       = 4'd8
    } sched_state_e;

    // Tile index width; a single-tile job still gets one bit.
    function automatic int tile_cw(input int nt);
        return (nt > 1) ? $clog2(nt) : 1;
    endfunction

endpackage

// File: rtl/matmul_tile_sched_if.sv
// Job command, array-controller handshake, tile indices, drain port and status of
// the tile scheduler, bundled for the scheduler (master) and its environment (slave).
interface matmul_tile_sched_if
    import matmul_tile_sched_pkg::*;
#(
    parameter int CW = 1
);
    logic           cmd_valid;
    logic           cmd_ready;
    logic           abort;
    logic           ctrl_start;
    logic           ctrl_busy;
    logic           ctrl_done;
    logic           acc_clear;
    logic [CW-1:0]  row_tile;
    logic [CW-1:0]  col_tile;
    logic [CW-1:0]  k_tile;
    logic           drain_valid;
    logic           drain_ready;
    logic [DRW-1:0] drain_row;
    logic           drain_last;
    logic           busy;
    logic           job_done;
    logic           err_timeout;

    modport master (
        input  cmd_valid, abort, ctrl_busy, ctrl_done, drain_ready,
        output cmd_ready, ctrl_start, acc_clear, row_tile, col_tile, k_tile,
               drain_valid, drain_row, drain_last, busy, job_done, err_timeout
    );

    modport slave (
        output cmd_valid, abort, ctrl_busy, ctrl_done, drain_ready,
        input  cmd_ready, ctrl_start, acc_clear, row_tile, col_tile, k_tile,
               drain_valid, drain_row, drain_last, busy, job_done, err_timeout
    );

endinterface

// File: rtl/matmul_tile_sched_tile_odometer.sv
// Three-digit (k, col, row) tile counter; k steps independently, col carries into row.
// Each digit wraps at NT by explicit compare; wrap flags are combinational.
module tile_odometer #(
    parameter int NT = 2,
    parameter int CW = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          inc_k_i,
    input  logic          inc_out_i,
    output logic [CW-1:0] k_o,
    output logic [CW-1:0] col_o,
    output logic [CW-1:0] row_o,
    output logic          k_wrap_o,
    output logic          col_wrap_o,
    output logic          row_wrap_o
);
    localparam logic [CW-1:0] LAST = CW'(NT - 1);

    logic [CW-1:0] k_q, k_d;
    logic [CW-1:0] col_q, col_d;
    logic [CW-1:0] row_q, row_d;

    assign k_wrap_o   = (k_q == LAST);
    assign col_wrap_o = (col_q == LAST);
    assign row_wrap_o = (row_q == LAST);
    assign k_o        = k_q;
    assign col_o      = col_q;
    assign row_o      = row_q;

    always_comb begin
        k_d   = k_q;
        col_d = col_q;
        row_d = row_q;
        if (clr_i) begin
            k_d   = '0;
            col_d = '0;
            row_d = '0;
        end else begin
            if (inc_k_i) begin
                k_d = k_wrap_o ? '0 : k_q + CW'(1);
            end
            if (inc_out_i) begin
                if (col_wrap_o) begin
                    col_d = '0;
                    row_d = row_wrap_o ? '0 : row_q + CW'(1);
                end else begin
                    col_d = col_q + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q   <= '0;
            col_q <= '0;
            row_q <= '0;
        end else begin
            k_q   <= k_d;
            col_q <= col_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/matmul_tile_sched.sv
// Job-level scheduler for one NxN matmul on the TILExTILE systolic array: walks output
// tiles row-major with K innermost, pulses the array controller, drains each tile.
module matmul_tile_sched
    import matmul_tile_sched_pkg::*;
#(
    parameter int N       = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    matmul_tile_sched_if.master bus
);
    localparam int              NT       = N / TILE;
    localparam int              CW       = tile_cw(NT);
    localparam logic [7:0]      WD_LAST  = 8'(TIMEOUT - 1);
    localparam logic [DRW-1:0]  ROW_LAST = DRW'(TILE - 1);

    if (N % TILE != 0) begin : g_bad_n
        $error("matmul_tile_sched: N must be a multiple of TILE");
    end

    sched_state_e   state_q;
    logic [7:0]     wd_q;
    logic [DRW-1:0] drain_row_q;
    logic           start_q;
    logic           err_q;

    logic           accept;
    logic           odo_clr;
    logic           inc_k;
    logic           inc_out;
    logic           k_wrap;
    logic           col_wrap;
    logic           row_wrap;
    logic [CW-1:0]  k_tile;
    logic [CW-1:0]  col_tile;
    logic [CW-1:0]  row_tile;

    assign accept  = (state_q == S_IDLE) && bus.cmd_valid;
    assign odo_clr = bus.abort || accept;
    assign inc_k   = (state_q == S_NEXT_K) && !bus.abort;
    assign inc_out = (state_q == S_NEXT_TILE) && !bus.abort;

    tile_odometer #(
        .NT (NT),
        .CW (CW)
    ) u_odometer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (odo_clr),
        .inc_k_i    (inc_k),
        .inc_out_i  (inc_out),
        .k_o        (k_tile),
        .col_o      (col_tile),
        .row_o      (row_tile),
        .k_wrap_o   (k_wrap),
        .col_wrap_o (col_wrap),
        .row_wrap_o (row_wrap)
    );

    // ctrl_start is registered so ctrl_busy never reaches an output combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wd_q        <= '0;
            drain_row_q <= '0;
            start_q     <= 1'b0;
            err_q       <= 1'b0;
        end else if (bus.abort) begin
            state_q     <= S_IDLE;
            wd_q        <= '0;
            drain_row_q <= '0;
            start_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            start_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (bus.cmd_valid) state_q <= S_CLEAR;
                end
                S_CLEAR: state_q <= S_ISSUE;
                S_ISSUE: begin
                    if (!bus.ctrl_busy) begin
                        start_q <= 1'b1;
                        wd_q    <= '0;
                        state_q <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (bus.ctrl_done) begin
                        state_q <= S_NEXT_K;
                    end else if (wd_q == WD_LAST) begin
                        err_q   <= 1'b1;
                        state_q <= S_ERR;
                    end else begin
                        wd_q <= wd_q + 8'd1;
                    end
                end
                S_NEXT_K: state_q <= k_wrap ? S_DRAIN : S_ISSUE;
                S_DRAIN: begin
                    if (bus.drain_ready) begin
                        if (drain_row_q == ROW_LAST) begin
                            drain_row_q <= '0;
                            state_q     <= S_NEXT_TILE;
                        end else begin
                            drain_row_q <= drain_row_q + DRW'(1);
                        end
                    end
                end
                // The odometer wraps row/col back to zero on the final tile.
                S_NEXT_TILE: state_q <= (row_wrap && col_wrap) ? S_DONE : S_CLEAR;
                S_DONE:      state_q <= S_IDLE;
                S_ERR:       state_q <= S_ERR;
                default:     state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready   = (state_q == S_IDLE);
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.acc_clear   = (state_q == S_CLEAR);
    assign bus.drain_valid = (state_q == S_DRAIN);
    assign bus.job_done    = (state_q == S_DONE);
    assign bus.ctrl_start  = start_q;
    assign bus.err_timeout = err_q;
    assign bus.drain_row   = drain_row_q;
    assign bus.row_tile    = row_tile;
    assign bus.col_tile    = col_tile;
    assign bus.k_tile      = k_tile;
    assign bus.drain_last  = (state_q == S_DRAIN) && row_wrap && col_wrap
                             && (drain_row_q == ROW_LAST);

endmodule

// File: tb/tb_matmul_tile_sched.sv
// Directed bench for matmul_tile_sched (N=8, NT=2): job walk order, drain stall,
// busy hold-off, watchdog/abort, async reset mid-drain and back-to-back jobs.
module tb_matmul_tile_sched;
    import matmul_tile_sched_pkg::*;

    localparam int TCW = 1;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    matmul_tile_sched_if #(.CW(TCW)) bus ();

    matmul_tile_sched #(
        .N       (8),
        .TIMEOUT (255)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Array-controller stand-in: ctrl_done five cycles after each ctrl_start.
    bit done_en;
    int done_cnt;
    always @(negedge clk) begin
        bus.ctrl_done = 1'b0;
        if (!done_en || !rst_n) begin
            done_cnt = 0;
        end else if (bus.ctrl_start) begin
            done_cnt = 5;
        end else if (done_cnt != 0) begin
            done_cnt = done_cnt - 1;
            if (done_cnt == 0) bus.ctrl_done = 1'b1;
        end
    end

    // Event monitor sampled mid-cycle, with an independent drain_last model.
    int n_start, n_clear, n_beat, n_done, n_last, n_last_bad;
    logic [TCW-1:0] log_r [128];
    logic [TCW-1:0] log_c [128];
    logic [TCW-1:0] log_k [128];
    initial begin
        n_start = 0; n_clear = 0; n_beat = 0; n_done = 0; n_last = 0; n_last_bad = 0;
    end
    always @(negedge clk) begin
        logic exp_last;
        if (bus.ctrl_start) begin
            if (n_start < 128) begin
                log_r[n_start] = bus.row_tile;
                log_c[n_start] = bus.col_tile;
                log_k[n_start] = bus.k_tile;
            end
            n_start = n_start + 1;
        end
        if (bus.acc_clear) n_clear = n_clear + 1;
        if (bus.drain_valid && bus.drain_ready) n_beat = n_beat + 1;
        if (bus.job_done) n_done = n_done + 1;
        exp_last = bus.drain_valid && (bus.row_tile == 1'b1) && (bus.col_tile == 1'b1)
                   && (bus.drain_row == 2'd3);
        if (bus.drain_last) n_last = n_last + 1;
        if (bus.drain_last !== exp_last) n_last_bad = n_last_bad + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job();
        bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_job_done(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (bus.job_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_full_job(input string tag);
        int b_start, b_clear, b_beat, b_done, b_last, b_lbad;
        bit seen;
        b_start = n_start; b_clear = n_clear; b_beat = n_beat;
        b_done = n_done; b_last = n_last; b_lbad = n_last_bad;
        total++;
        if (bus.cmd_ready !== 1'b1) begin
            bad++; $display("[TB] FAIL %s_ready: got %b want 1", tag, bus.cmd_ready);
        end
        start_job();
        wait_job_done(3000, seen);
        total++;
        if (!seen) begin
            bad++; $display("[TB] FAIL %s_done_timeout: got 0 want 1", tag);
        end
        repeat (2) tick();
        total++;
        if (n_start - b_start !== 8) begin
            bad++; $display("[TB] FAIL %s_starts: got %0d want 8", tag, n_start - b_start);
        end
        total++;
        if (n_clear - b_clear !== 4) begin
            bad++; $display("[TB] FAIL %s_clears: got %0d want 4", tag, n_clear - b_clear);
        end
        total++;
        if (n_beat - b_beat !== 16) begin
            bad++; $display("[TB] FAIL %s_beats: got %0d want 16", tag, n_beat - b_beat);
        end
        total++;
        if (n_done - b_done !== 1) begin
            bad++; $display("[TB] FAIL %s_job_done: got %0d want 1", tag, n_done - b_done);
        end
        total++;
        if (n_last - b_last !== 1 || n_last_bad !== b_lbad) begin
            bad++;
            $display("[TB] FAIL %s_drain_last: got count=%0d wrong=%0d want count=1 wrong=0",
                     tag, n_last - b_last, n_last_bad - b_lbad);
        end
        for (int i = 0; i < 8; i++) begin
            logic [2:0] got, want;
            int idx;
            idx  = b_start + i;
            want = 3'(i);
            got  = (idx < 128) ? {log_r[idx], log_c[idx], log_k[idx]} : 3'b000;
            total++;
            if (got !== want) begin
                bad++; $display("[TB] FAIL %s_order%0d: got rck=%b want rck=%b", tag, i, got, want);
            end
        end
        total++;
        if (bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL %s_idle_after: got busy=%b ready=%b want busy=0 ready=1",
                     tag, bus.busy, bus.cmd_ready);
        end
    endtask

    task automatic test_reset();
        #3;
        total++;
        if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0 || bus.ctrl_start !== 1'b0 ||
            bus.acc_clear !== 1'b0 || bus.drain_valid !== 1'b0 || bus.job_done !== 1'b0 ||
            bus.err_timeout !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got ready=%b busy=%b start=%b clr=%b dv=%b done=%b err=%b want 1000000",
                     bus.cmd_ready, bus.busy, bus.ctrl_start, bus.acc_clear, bus.drain_valid,
                     bus.job_done, bus.err_timeout);
        end
        #9 rst_n = 1'b1;
        tick();
        total++;
        if ({bus.row_tile, bus.col_tile, bus.k_tile, bus.drain_row} !== 5'b0 ||
            bus.cmd_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_counters: got rck=%b%b%b drow=%0d ready=%b want 000 0 1",
                     bus.row_tile, bus.col_tile, bus.k_tile, bus.drain_row, bus.cmd_ready);
        end
    endtask

    task automatic test_full_job();
        run_full_job("full");
    endtask

    task automatic test_drain_stall();
        int  b_beat;
        bit  hit;
        bit  seen;
        b_beat = n_beat;
        start_job();
        hit = 1'b0;
        for (int i = 0; i < 500; i++) begin
            tick();
            if (bus.drain_valid === 1'b1 && bus.drain_row === 2'd2) begin
                hit = 1'b1;
                break;
            end
        end
        bus.drain_ready = 1'b0;
        total++;
        if (!hit) begin
            bad++; $display("[TB] FAIL stall_reach_row2: got 0 want 1");
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (bus.drain_valid !== 1'b1 || bus.drain_row !== 2'd2) begin
                bad++;
                $display("[TB] FAIL stall_hold%0d: got valid=%b row=%0d want valid=1 row=2",
                         i, bus.drain_valid, bus.drain_row);
            end
        end
        bus.drain_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.drain_valid !== 1'b1) break;
        end
        total++;
        if (n_beat - b_beat !== 4) begin
            bad++; $display("[TB] FAIL stall_tile_beats: got %0d want 4", n_beat - b_beat);
        end
        wait_job_done(3000, seen);
        repeat (2) tick();
        total++;
        if (!seen || n_beat - b_beat !== 16) begin
            bad++; $display("[TB] FAIL stall_job_beats: got %0d done=%b want 16 done=1",
                            n_beat - b_beat, seen);
        end
    endtask

    task automatic test_busy_hold();
        int b_start;
        bit seen;
        b_start = n_start;
        bus.ctrl_busy = 1'b1;
        start_job();
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if (bus.ctrl_start !== 1'b0) begin
                bad++; $display("[TB] FAIL busy_no_start%0d: got %b want 0", i, bus.ctrl_start);
            end
        end
        bus.ctrl_busy = 1'b0;
        tick();
        total++;
        if (bus.ctrl_start !== 1'b1) begin
            bad++; $display("[TB] FAIL busy_release_start: got %b want 1", bus.ctrl_start);
        end
        wait_job_done(3000, seen);
        repeat (2) tick();
        total++;
        if (!seen || n_start - b_start !== 8) begin
            bad++; $display("[TB] FAIL busy_job_starts: got %0d done=%b want 8 done=1",
                            n_start - b_start, seen);
        end
    endtask

    task automatic test_timeout_abort();
        int cyc;
        bit hit;
        done_en = 1'b0;
        start_job();
        hit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.ctrl_start === 1'b1) begin
                hit = 1'b1;
                break;
            end
        end
        total++;
        if (!hit) begin
            bad++; $display("[TB] FAIL timeout_start_seen: got 0 want 1");
        end
        cyc = 0;
        for (int i = 0; i < 400; i++) begin
            tick();
            cyc++;
            if (bus.err_timeout === 1'b1) break;
        end
        total++;
        if (cyc !== 255 || bus.err_timeout !== 1'b1) begin
            bad++; $display("[TB] FAIL timeout_latency: got %0d err=%b want 255 err=1",
                            cyc, bus.err_timeout);
        end
        repeat (3) tick();
        total++;
        if (bus.err_timeout !== 1'b1 || bus.busy !== 1'b1 || bus.ctrl_start !== 1'b0 ||
            bus.cmd_ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL timeout_sticky: got err=%b busy=%b start=%b ready=%b want 1 1 0 0",
                     bus.err_timeout, bus.busy, bus.ctrl_start, bus.cmd_ready);
        end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        total++;
        if (bus.cmd_ready !== 1'b1 || bus.err_timeout !== 1'b0 || bus.busy !== 1'b0 ||
            bus.job_done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL abort_idle: got ready=%b err=%b busy=%b done=%b want 1 0 0 0",
                     bus.cmd_ready, bus.err_timeout, bus.busy, bus.job_done);
        end
        done_en = 1'b1;
        tick();
    endtask

    task automatic test_async_reset();
        bit hit;
        start_job();
        hit = 1'b0;
        for (int i = 0; i < 500; i++) begin
            tick();
            if (bus.drain_valid === 1'b1 && bus.col_tile === 1'b1) begin
                hit = 1'b1;
                break;
            end
        end
        total++;
        if (!hit) begin
            bad++; $display("[TB] FAIL areset_reach_drain: got 0 want 1");
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (bus.drain_valid !== 1'b0 || bus.busy !== 1'b0 || bus.col_tile !== 1'b0 ||
            bus.cmd_ready !== 1'b1 || bus.drain_row !== 2'd0) begin
            bad++;
            $display("[TB] FAIL areset_immediate: got dv=%b busy=%b col=%b ready=%b drow=%0d want 0 0 0 1 0",
                     bus.drain_valid, bus.busy, bus.col_tile, bus.cmd_ready, bus.drain_row);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        run_full_job("areset");
    endtask

    task automatic test_back_to_back();
        int b_done, b_clear;
        bit seen;
        b_done  = n_done;
        b_clear = n_clear;
        bus.cmd_valid = 1'b1;
        wait_job_done(3000, seen);
        total++;
        if (!seen) begin
            bad++; $display("[TB] FAIL b2b_first_done: got 0 want 1");
        end
        tick();
        total++;
        if (bus.cmd_ready !== 1'b1) begin
            bad++; $display("[TB] FAIL b2b_ready_after_done: got %b want 1", bus.cmd_ready);
        end
        tick();
        total++;
        if (bus.acc_clear !== 1'b1) begin
            bad++; $display("[TB] FAIL b2b_second_accept: got clr=%b want 1", bus.acc_clear);
        end
        bus.cmd_valid = 1'b0;
        repeat (5) tick();
        bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        wait_job_done(3000, seen);
        repeat (10) tick();
        total++;
        if (!seen || n_done - b_done !== 2 || n_clear - b_clear !== 8 ||
            bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL b2b_totals: got jobs=%0d clears=%0d busy=%b want 2 8 0",
                     n_done - b_done, n_clear - b_clear, bus.busy);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        done_en = 1'b1;
        bus.cmd_valid   = 1'b0;
        bus.abort       = 1'b0;
        bus.ctrl_busy   = 1'b0;
        bus.drain_ready = 1'b1;
        $display("[TB] starting matmul_tile_sched bench");
        test_reset();
        test_full_job();
        test_drain_stall();
        test_busy_hold();
        test_timeout_abort();
        test_async_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
